// File: rtl/fp_mult_pkg.sv
// Shared constants and state encoding for the iterative FP multiplier.
// Also used by the round/pack stage.
package fp_mult_pkg;

    localparam int WIDTH     = 32;
    localparam int EXP_WIDTH = 8;
    localparam int SIG_WIDTH = 23;
    localparam int BIAS      = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EXP_ONES  = (1 << EXP_WIDTH) - 1;

    localparam int MW = SIG_WIDTH + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_WIDTH + 2;
    localparam int CW = $clog2(MW);

    localparam logic [WIDTH-1:0] QNAN = {
        1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH - 1){1'b0}}
    };

    typedef enum logic [2:0] {
        IDLE,
        SPEC,
        MUL,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise, round-to-nearest-even, range check and pack.
// Expects a product of two 1.x significands, i.e. a value in [1,4).
module fp_round_pack
    import fp_mult_pkg::*;
(
    input  logic                 sign,
    input  logic signed [EW-1:0] exp_in,
    input  logic [PW-1:0]        prod,
    output logic [WIDTH-1:0]     word
);

    logic [SIG_WIDTH-1:0] frac;
    logic                 guard;
    logic                 sticky;
    logic                 up;
    logic [SIG_WIDTH:0]   rnd;
    logic signed [EW-1:0] exp_n;
    logic signed [EW-1:0] exp_r;

    always_comb begin
        if (prod[PW-1]) begin
            frac   = prod[PW-2 -: SIG_WIDTH];
            guard  = prod[PW-2-SIG_WIDTH];
            sticky = |prod[PW-3-SIG_WIDTH:0];
            exp_n  = exp_in + EW'(1);
        end else begin
            frac   = prod[PW-3 -: SIG_WIDTH];
            guard  = prod[PW-3-SIG_WIDTH];
            sticky = |prod[PW-4-SIG_WIDTH:0];
            exp_n  = exp_in;
        end

        up  = guard & (sticky | frac[0]);
        rnd = {1'b0, frac} + {{SIG_WIDTH{1'b0}}, up};

        // carry-out leaves the fraction all-zero, only the exponent moves
        exp_r = rnd[SIG_WIDTH] ? exp_n + EW'(1) : exp_n;

        if (exp_r >= $signed(EW'(EXP_ONES)))
            word = {sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        else if (exp_r <= $signed(EW'(0)))
            word = {sign, {(WIDTH - 1){1'b0}}};
        else
            word = {sign, exp_r[EXP_WIDTH-1:0], rnd[SIG_WIDTH-1:0]};
    end

endmodule

// File: rtl/fp_mult_core.sv
// Iterative single-precision multiplier: special-case bypass or
// LSB-first shift-add significand multiply, then round and pack.
module fp_mult_core
    import fp_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_zero,
    input  logic             b_zero,
    input  logic             set_nan,
    input  logic             set_inf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    state_t               state;
    state_t               nxt;
    logic                 sign;
    logic [EXP_WIDTH-1:0] ea;
    logic [EXP_WIDTH-1:0] eb;
    logic [MW-1:0]        ma;
    logic [MW-1:0]        mb;
    logic [PW-1:0]        acc;
    logic [CW-1:0]        cnt;
    logic                 fz;
    logic                 fnan;
    logic                 finf;
    logic                 accept;
    logic                 special;
    logic [MW:0]          sum;
    logic signed [EW-1:0] exp_base;
    logic [WIDTH-1:0]     spec_word;
    logic [WIDTH-1:0]     norm_word;

    assign accept  = in_valid & in_ready;
    assign special = set_nan | set_inf | a_zero | b_zero;
    assign sum     = {1'b0, acc[PW-1:MW]} + {1'b0, {MW{mb[0]}} & ma};

    assign exp_base = $signed({2'b00, ea}) + $signed({2'b00, eb})
                    - $signed(EW'(BIAS));

    always_comb begin
        if (fnan | (finf & fz))
            spec_word = QNAN;
        else if (finf)
            spec_word = {sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        else
            spec_word = {sign, {(WIDTH - 1){1'b0}}};
    end

    fp_round_pack u_round_pack (
        .sign   (sign),
        .exp_in (exp_base),
        .prod   (acc),
        .word   (norm_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (accept) nxt = special ? SPEC : MUL;
            SPEC: nxt = DONE;
            MUL:  if (cnt == CW'(SIG_WIDTH)) nxt = NORM;
            NORM: nxt = DONE;
            DONE: if (out_valid && out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            sign      <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            cnt       <= '0;
            fz        <= 1'b0;
            fnan      <= 1'b0;
            finf      <= 1'b0;
        end else begin
            in_ready <= (nxt == IDLE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= a[WIDTH-1] ^ b[WIDTH-1];
                        ea   <= a[WIDTH-2 -: EXP_WIDTH];
                        eb   <= b[WIDTH-2 -: EXP_WIDTH];
                        ma   <= {1'b1, a[SIG_WIDTH-1:0]};
                        mb   <= {1'b1, b[SIG_WIDTH-1:0]};
                        acc  <= '0;
                        cnt  <= '0;
                        fz   <= a_zero | b_zero;
                        fnan <= set_nan;
                        finf <= set_inf;
                    end
                end
                SPEC: result <= spec_word;
                MUL: begin
                    acc <= {sum, acc[MW-1:1]};
                    mb  <= {1'b0, mb[MW-1:1]};
                    cnt <= cnt + CW'(1);
                end
                NORM: result <= norm_word;
                DONE: begin
                    if (!out_valid)
                        out_valid <= 1'b1;
                    else if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
